blink_code_sequencer: RTL and testbench

Time-shares a single status LED between several requesters, each reporting a small numeric code as a train of blinks followed by a dark gap. A round-robin arbiter selects one requester, and a four-state FSM drives the LED at the same on/off cadence as the plain blinker. The block sits between fault/status sources and the board LED pin.

---
 rtl/blink_seq_pkg.sv | 25 ++
 rtl/blink_seq_timer.sv | 33 +++
 rtl/blink_code_sequencer.sv | 167 ++++++++++++++++
 tb/tb_blink_code_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/blink_seq_pkg.sv
// Shared types and sizing helpers for the blink code sequencer.
package blink_seq_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StOn,
        StOff,
        StGap
    } state_e;

    function automatic int unsigned clocks_per_edge(input int unsigned clocks_per_period);
        return clocks_per_period / 2;
    endfunction

    function automatic int unsigned gap_cycles(input int unsigned clocks_per_period,
                                               input int unsigned gap_periods);
        return clocks_per_period * gap_periods;
    endfunction

    function automatic int unsigned timer_w(input int unsigned clocks_per_period,
                                            input int unsigned gap_periods);
        return $clog2(clocks_per_period * gap_periods);
    endfunction

endpackage

// File: rtl/blink_seq_timer.sv
// Loadable down-counter that parks at zero; expired_o flags a zero count.
module blink_seq_timer #(
    parameter int unsigned Width = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [Width-1:0] load_value_i,
    output logic             expired_o
);

    logic [Width-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_value_i;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == '0);

endmodule

// File: rtl/blink_code_sequencer.sv
// Round-robin shared status LED: each requester's code is shown as code+1 blinks then a gap.
// Optional idle heartbeat on the LED when BLINK_SEQ_HEARTBEAT_EN is defined.
module blink_code_sequencer
    import blink_seq_pkg::*;
#(
    parameter int unsigned CLOCKS_PER_PERIOD = 50_000_000,
    parameter int unsigned NUM_REQ           = 4,
    parameter int unsigned CODE_W            = 3,
    parameter int unsigned GAP_PERIODS       = 3,
    localparam int unsigned ID_W             = $clog2(NUM_REQ)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NUM_REQ-1:0]       req_i,
    input  logic [NUM_REQ*CODE_W-1:0] code_i,
    output logic                     led_o,
    output logic                     busy_o,
    output logic [ID_W-1:0]          active_id_o,
    output logic                     done_o
);

    localparam int unsigned ClocksPerEdge = clocks_per_edge(CLOCKS_PER_PERIOD);
    localparam int unsigned GapCycles     = gap_cycles(CLOCKS_PER_PERIOD, GAP_PERIODS);
    localparam int unsigned TimerW        = timer_w(CLOCKS_PER_PERIOD, GAP_PERIODS);

    localparam logic [TimerW-1:0] EdgeLoad = TimerW'(ClocksPerEdge - 1);
    localparam logic [TimerW-1:0] GapLoad  = TimerW'(GapCycles - 1);

    state_e              state_q, state_d;
    logic [CODE_W-1:0]   blinks_left_q, blinks_left_d;
    logic [ID_W-1:0]     active_id_q, active_id_d;
    logic [ID_W-1:0]     last_grant_q, last_grant_d;
    logic                led_q, led_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                tmr_load;
    logic [TimerW-1:0]   tmr_load_value;
    logic                tmr_expired;

    logic                grant_valid;
    logic [ID_W-1:0]     grant_idx;
    logic [ID_W-1:0]     scan_idx;
    logic [CODE_W-1:0]   sel_code;

    blink_seq_timer #(
        .Width(TimerW)
    ) u_timer (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .load_i      (tmr_load),
        .load_value_i(tmr_load_value),
        .expired_o   (tmr_expired)
    );

    // Scan upward from the index after the last grant, wrapping, first hit wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            scan_idx = ID_W'((32'(last_grant_q) + k) % NUM_REQ);
            if (!grant_valid && req_i[scan_idx]) begin
                grant_valid = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        sel_code = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == ID_W'(i)) begin
                sel_code = code_i[i*CODE_W +: CODE_W];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q       <= StIdle;
            blinks_left_q <= '0;
            active_id_q   <= '0;
            last_grant_q  <= ID_W'(NUM_REQ - 1);
            led_q         <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            blinks_left_q <= blinks_left_d;
            active_id_q   <= active_id_d;
            last_grant_q  <= last_grant_d;
            led_q         <= led_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        blinks_left_d  = blinks_left_q;
        active_id_d    = active_id_q;
        last_grant_d   = last_grant_q;
        tmr_load       = 1'b0;
        tmr_load_value = EdgeLoad;
        unique case (state_q)
            StIdle: begin
                if (grant_valid) begin
                    state_d       = StOn;
                    blinks_left_d = sel_code;
                    active_id_d   = grant_idx;
                    last_grant_d  = grant_idx;
                    tmr_load      = 1'b1;
`ifdef BLINK_SEQ_HEARTBEAT_EN
                end else if (tmr_expired) begin
                    tmr_load = 1'b1;
`endif
                end
            end
            StOn: begin
                if (tmr_expired) begin
                    tmr_load = 1'b1;
                    if (blinks_left_q != '0) begin
                        blinks_left_d = blinks_left_q - 1'b1;
                        state_d       = StOff;
                    end else begin
                        tmr_load_value = GapLoad;
                        state_d        = StGap;
                    end
                end
            end
            StOff: begin
                if (tmr_expired) begin
                    tmr_load = 1'b1;
                    state_d  = StOn;
                end
            end
            StGap: begin
                if (tmr_expired) begin
                    state_d = StIdle;
`ifdef BLINK_SEQ_HEARTBEAT_EN
                    tmr_load = 1'b1;
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are computed from the next state so they can be registered without lag.
    always_comb begin
        busy_d = (state_d != StIdle);
        done_d = (state_q == StGap) && (state_d == StIdle);
        led_d  = (state_d == StOn);
`ifdef BLINK_SEQ_HEARTBEAT_EN
        if (state_q == StIdle && state_d == StIdle) begin
            led_d = tmr_expired ? ~led_q : led_q;
        end
`endif
    end

    assign led_o       = led_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign active_id_o = active_id_q;

endmodule

// File: tb/tb_blink_code_sequencer.sv
// Directed and randomized checks of blink_code_sequencer against an offset-based reference model.
module tb_blink_code_sequencer;

    localparam int CPP   = 4;
    localparam int NR    = 4;
    localparam int CW    = 3;
    localparam int GP    = 2;
    localparam int CPE   = CPP / 2;
    localparam int GAPC  = CPP * GP;
    localparam int IDW   = 2;
    localparam int CODEB = NR * CW;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic [NR-1:0]     req   = '0;
    logic [CODEB-1:0]  code  = '0;
    logic              led, busy, done;
    logic [IDW-1:0]    active_id;

    int n_cmp  = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;

    blink_code_sequencer #(
        .CLOCKS_PER_PERIOD(CPP),
        .NUM_REQ          (NR),
        .CODE_W           (CW),
        .GAP_PERIODS      (GP)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .req_i      (req),
        .code_i     (code),
        .led_o      (led),
        .busy_o     (busy),
        .active_id_o(active_id),
        .done_o     (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Model: m_pos is the 1-based cycle offset inside the running sequence (0 = idle).
    int m_pos  = 0;
    int m_len  = 0;
    int m_code = 0;
    int m_id   = 0;
    int m_last = NR - 1;
    int m_done = 0;
    int m_found;
    int m_idx;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_pos  = 0;
            m_done = 0;
            m_id   = 0;
            m_last = NR - 1;
        end else if (m_pos == 0) begin
            m_done  = 0;
            m_found = 0;
            for (int k = 1; k <= NR; k++) begin
                m_idx = (m_last + k) % NR;
                if (m_found == 0 && req[m_idx]) begin
                    m_found = 1;
                    m_id    = m_idx;
                    m_code  = int'((code >> (m_idx * CW)) & CODEB'((1 << CW) - 1));
                    m_len   = (2 * m_code + 1) * CPE + GAPC;
                    m_pos   = 1;
                end
            end
            if (m_found != 0) m_last = m_id;
        end else begin
            m_done = 0;
            if (m_pos == m_len) begin
                m_pos  = 0;
                m_done = 1;
            end else begin
                m_pos++;
            end
        end
    end

    function automatic int model_led(input int pos, input int c);
        if (pos == 0) return 0;
        if (pos - 1 >= (2 * c + 1) * CPE) return 0;
        return (((pos - 1) / CPE) % 2 == 0) ? 1 : 0;
    endfunction

    always @(negedge clk) begin
        if (cmp_en) begin
            check("led", int'(led), model_led(m_pos, m_code));
            check("busy", int'(busy), (m_pos != 0) ? 1 : 0);
            check("done", int'(done), m_done);
            check("active_id", int'(active_id), m_id);
        end
    end

    task automatic wait_busy(input string name);
        int n = 0;
        while (!busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!busy) check(name, 0, 1);
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!done) check(name, 0, 1);
    endtask

    int exp_single_led[16]  = '{0, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    int exp_single_busy[16] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    int exp_single_done[16] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    int exp_rr_ids[4]       = '{0, 2, 0, 2};

    initial begin
        int busy_cnt;
        int pulses;
        int prev_led;
        int guard;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        cmp_en = 1'b1;
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("reset_led", int'(led), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_id", int'(active_id), 0);

        // Single code 1 on requester 0.
        code = CODEB'(12'h001);
        req  = 4'b0001;
        @(posedge clk);
        #2 req = 4'b0000;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            check("single_led", int'(led), exp_single_led[k]);
            check("single_busy", int'(busy), exp_single_busy[k]);
            check("single_done", int'(done), exp_single_done[k]);
        end

        // Maximum code 7.
        code = CODEB'(12'h007);
        req  = 4'b0001;
        @(posedge clk);
        #2 req = 4'b0000;
        busy_cnt = 0;
        pulses   = 0;
        prev_led = 0;
        guard    = 0;
        @(negedge clk);
        while (!done && guard < 100) begin
            if (busy) busy_cnt++;
            if (led && prev_led == 0) pulses++;
            prev_led = int'(led);
            guard++;
            @(negedge clk);
        end
        check("max_done_seen", int'(done), 1);
        check("max_busy_cycles", busy_cnt, 38);
        check("max_on_pulses", pulses, 8);

        // Round robin between requesters 0 and 2 after a fresh reset.
        rst_n = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        code  = '0;
        req   = 4'b0101;
        @(negedge clk);
        for (int g = 0; g < 4; g++) begin
            wait_busy("rr_busy_timeout");
            check("rr_id", int'(active_id), exp_rr_ids[g]);
            wait_done("rr_done_timeout");
            check("rr_done_not_busy", int'(busy), 0);
            if (g < 3) begin
                @(negedge clk);
                check("rr_back_to_back", int'(busy), 1);
            end
        end

        // Reset during OFF, then requester 0 wins again over requester 1.
        req  = 4'b0011;
        code = CODEB'(12'h019);
        wait_busy("rst_busy_timeout");
        check("rst_first_id", int'(active_id), 0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("rst_led", int'(led), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        @(negedge clk);
        check("rst_regrant_busy", int'(busy), 1);
        check("rst_regrant_id", int'(active_id), 0);

        // Randomized traffic including mid-sequence req/code changes and resets.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #2;
            if ($urandom_range(0, 7) == 0) req = NR'($urandom);
            if ($urandom_range(0, 3) == 0) code = CODEB'($urandom);
            rst_n = ($urandom_range(0, 249) != 0);
        end
        rst_n = 1'b1;
        req   = '0;
        repeat (60) @(posedge clk);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
